// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared types and helpers for the UART receive path.
//   rx_state_e    : receive FSM state encoding
//   clks_per_bit  : integer clocks per serial bit (freq / baud)
//   UART_BAUD     : default line rate
//   UART_CLK      : default system clock frequency
// ---------------------------------------------------------------------------
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      BREAK
   } rx_state_e;

   localparam int UART_BAUD = 115200;
   localparam int UART_CLK  = 200_000_000;

   function automatic int clks_per_bit(input int freq, input int baud);
      return freq / baud;
   endfunction

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Two-flop synchronizer for a single asynchronous bit.
//   clock : destination clock
//   reset : asynchronous, active-high; both flops load RESET_VAL
//   d     : asynchronous input
//   q     : synchronized output (two clocks of latency)
// ---------------------------------------------------------------------------
module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_rx_deser.sv
// ---------------------------------------------------------------------------
// uart_rx_deser
// UART receive deserializer: 8N1 frames (8E1 when UART_RX_PARITY_EN is
// defined), LSB first, presented on a valid/ready holding register.
//   clock      : system clock
//   reset      : asynchronous, active-high
//   sig_rx     : serial line, idles high
//   data       : received byte, stable while valid
//   valid      : byte available
//   ready      : consumer accepts when valid && ready
//   frame_err  : 1-cycle pulse, stop bit sampled low
//   overrun    : 1-cycle pulse, byte completed while holding register full
//   parity_err : 1-cycle pulse on even-parity mismatch (0 without the option)
// Build option: `define UART_RX_PARITY_EN inserts an even-parity bit.
// ---------------------------------------------------------------------------
module uart_rx_deser
   import uart_pkg::*;
#(
   parameter int DATA_WIDTH = 8,
   parameter int BAUD_RATE  = UART_BAUD,
   parameter int CLK_FREQ   = UART_CLK
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  sig_rx,
   output logic [DATA_WIDTH-1:0] data,
   output logic                  valid,
   input  logic                  ready,
   output logic                  frame_err,
   output logic                  overrun,
   output logic                  parity_err
);

   localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD_RATE);
   localparam int CNT_W        = $clog2(CLKS_PER_BIT);
   localparam int IDX_W        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   localparam logic [CNT_W-1:0] HALF_LOAD = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LOAD  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DATA_WIDTH - 1);

   if (CLKS_PER_BIT < 4) begin : g_bad_rate
      $error("uart_rx_deser: CLKS_PER_BIT must be >= 4");
   end

   logic                  rx_s;
   rx_state_e             state, state_n;
   logic [CNT_W-1:0]      cnt, cnt_n;
   logic [IDX_W-1:0]      bit_idx, idx_n;
   logic                  shift_en;
   logic                  stop_ok;
   logic                  stop_bad;
   logic                  par_bad;
   logic [DATA_WIDTH-1:0] shift_reg;

   logic                  commit_p0;
   logic                  frame_p0;
   logic [DATA_WIDTH-1:0] byte_p0;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clock (clock),
      .reset (reset),
      .d     (sig_rx),
      .q     (rx_s)
   );

`ifdef UART_RX_PARITY_EN
   logic par_en;
`endif

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         bit_idx <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         bit_idx <= idx_n;
      end
   end

   // Every sample point is where the down-counter reaches zero; the first
   // load is half a bit so later samples land mid-bit.
   always_comb begin
      state_n  = state;
      cnt_n    = cnt;
      idx_n    = bit_idx;
      shift_en = 1'b0;
      stop_ok  = 1'b0;
      stop_bad = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_en   = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (!rx_s) begin
               state_n = START;
               cnt_n   = HALF_LOAD;
            end
         end
         START: begin
            if (cnt == '0) begin
               if (!rx_s) begin
                  state_n = DATA;
                  cnt_n   = BIT_LOAD;
                  idx_n   = '0;
               end else begin
                  state_n = IDLE;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         DATA: begin
            if (cnt == '0) begin
               shift_en = 1'b1;
               cnt_n    = BIT_LOAD;
               if (bit_idx == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  idx_n = bit_idx + 1'b1;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (cnt == '0) begin
               par_en  = 1'b1;
               cnt_n   = BIT_LOAD;
               state_n = STOP;
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
`endif
         STOP: begin
            if (cnt == '0) begin
               if (rx_s) begin
                  stop_ok = 1'b1;
                  state_n = IDLE;
               end else begin
                  stop_bad = 1'b1;
                  state_n  = BREAK;
               end
            end else begin
               cnt_n = cnt - 1'b1;
            end
         end
         BREAK: begin
            // A line held low must go high before a new start bit is accepted.
            if (rx_s) state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (shift_en) shift_reg <= {rx_s, shift_reg[DATA_WIDTH-1:1]};
   end

`ifdef UART_RX_PARITY_EN
   // Even parity: the data bits together with the parity bit XOR to zero.
   always_ff @(posedge clock or posedge reset) begin
      if (reset)       par_bad <= 1'b0;
      else if (par_en) par_bad <= (^shift_reg) ^ rx_s;
   end
`else
   assign par_bad = 1'b0;
`endif

   // ---- p0: stop-bit sample -> commit request ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         commit_p0 <= 1'b0;
         frame_p0  <= 1'b0;
      end else begin
         commit_p0 <= stop_ok && !par_bad;
         frame_p0  <= stop_bad;
      end
   end

   always_ff @(posedge clock) begin
      if (stop_ok) byte_p0 <= shift_reg;
   end

`ifdef UART_RX_PARITY_EN
   logic perr_p0;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         perr_p0    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         perr_p0    <= (stop_ok || stop_bad) && par_bad;
         parity_err <= perr_p0;
      end
   end
`else
   assign parity_err = 1'b0;
`endif

   // ---- commit: holding register and handshake ----
   // A commit into a register being drained this same cycle reloads it
   // without a bubble; a commit into a held register is dropped.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         data      <= '0;
         valid     <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         frame_err <= frame_p0;
         overrun   <= commit_p0 && valid && !ready;
         if (commit_p0 && (!valid || ready)) begin
            data  <= byte_p0;
            valid <= 1'b1;
         end else if (valid && ready) begin
            valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx_deser.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_deser
// Directed bench for uart_rx_deser at 1.8432 MHz / 115200 baud (16 clocks
// per bit). Parity scenarios run when UART_RX_PARITY_EN is defined.
// ---------------------------------------------------------------------------
module tb_uart_rx_deser;
   import uart_pkg::*;

   localparam int CLK_F = 1_843_200;
   localparam int BAUD  = 115200;
   localparam int CPB   = 16;

   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       sig_rx = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       frame_err;
   logic       overrun;
   logic       parity_err;

   int checks = 0;
   int passed = 0;
   int cyc = 0;

   int         n_valid, n_frame, n_over, n_par, first_valid;
   logic [7:0] last_data;

   uart_rx_deser #(
      .DATA_WIDTH (8),
      .BAUD_RATE  (BAUD),
      .CLK_FREQ   (CLK_F)
   ) dut (
      .clock      (clock),
      .reset      (reset),
      .sig_rx     (sig_rx),
      .data       (data),
      .valid      (valid),
      .ready      (ready),
      .frame_err  (frame_err),
      .overrun    (overrun),
      .parity_err (parity_err)
   );

   always #5 clock = ~clock;

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
      $fatal(1);
   end

   task automatic clear_mon();
      n_valid = 0; n_frame = 0; n_over = 0; n_par = 0;
      first_valid = -1; last_data = 8'h00;
   endtask

   // One clock: wait past the edge, then observe outputs.
   task automatic tick();
      @(posedge clock);
      #1;
      cyc++;
      if (valid) begin
         n_valid++;
         last_data = data;
         if (first_valid < 0) first_valid = cyc;
      end
      if (frame_err)  n_frame++;
      if (overrun)    n_over++;
      if (parity_err) n_par++;
   endtask

   task automatic idle(input int n);
      repeat (n) tick();
   endtask

   task automatic send_bit(input logic b);
      sig_rx = b;
      repeat (CPB) tick();
   endtask

   // par < 0 means no parity bit; otherwise par[0] is sent as the parity bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input int par, output int t0);
      t0 = cyc + 1;
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      if (par >= 0) send_bit(par[0]);
      send_bit(stop_bit);
      sig_rx = 1'b1;
   endtask

   task automatic test_reset();
      reset = 1'b1; sig_rx = 1'b1; ready = 1'b0;
      clear_mon();
      idle(3);
      checks++; if (data !== 8'h00) $display("FAIL reset_data: got %h want 00", data); else passed++;
      checks++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", valid); else passed++;
      checks++; if ({frame_err, overrun, parity_err} !== 3'b000)
         $display("FAIL reset_pulses: got %b want 000", {frame_err, overrun, parity_err}); else passed++;
      checks++; if (dut.state !== IDLE) $display("FAIL reset_state: got %0d want IDLE", dut.state); else passed++;
      reset = 1'b0;
      idle(5);
   endtask

   task automatic test_single();
      int t0;
      ready = 1'b1;
      clear_mon();
      send_frame(8'h61, 1'b1, -1, t0);
      idle(30);
      checks++; if (first_valid - t0 < 154 || first_valid - t0 > 156)
         $display("FAIL single_latency: got %0d want 155", first_valid - t0); else passed++;
      checks++; if (n_valid !== 1) $display("FAIL single_valid_cycles: got %0d want 1", n_valid); else passed++;
      checks++; if (last_data !== 8'h61) $display("FAIL single_data: got %h want 61", last_data); else passed++;
      checks++; if (n_frame + n_over + n_par !== 0)
         $display("FAIL single_err_pulses: got %0d want 0", n_frame + n_over + n_par); else passed++;
   endtask

   task automatic test_glitch();
      clear_mon();
      sig_rx = 1'b0;
      idle(4);
      sig_rx = 1'b1;
      idle(400);
      checks++; if (n_valid !== 0) $display("FAIL glitch_valid: got %0d want 0", n_valid); else passed++;
      checks++; if (n_frame !== 0) $display("FAIL glitch_frame_err: got %0d want 0", n_frame); else passed++;
      checks++; if (n_over !== 0)  $display("FAIL glitch_overrun: got %0d want 0", n_over); else passed++;
      checks++; if (dut.state !== IDLE) $display("FAIL glitch_state: got %0d want IDLE", dut.state); else passed++;
   endtask

   task automatic test_frame_err();
      int t0;
      ready = 1'b1;
      clear_mon();
      send_frame(8'h55, 1'b0, -1, t0);
      sig_rx = 1'b0;
      idle(40);
      sig_rx = 1'b1;
      idle(20);
      checks++; if (n_frame !== 1) $display("FAIL ferr_pulses: got %0d want 1", n_frame); else passed++;
      checks++; if (n_valid !== 0) $display("FAIL ferr_valid: got %0d want 0", n_valid); else passed++;
      clear_mon();
      send_frame(8'hA5, 1'b1, -1, t0);
      idle(30);
      checks++; if (n_valid !== 1) $display("FAIL ferr_next_valid: got %0d want 1", n_valid); else passed++;
      checks++; if (last_data !== 8'hA5) $display("FAIL ferr_next_data: got %h want a5", last_data); else passed++;
      checks++; if (n_frame !== 0) $display("FAIL ferr_next_frame: got %0d want 0", n_frame); else passed++;
   endtask

   task automatic test_back_to_back();
      int t0;
      ready = 1'b0;
      clear_mon();
      send_frame(8'h01, 1'b1, -1, t0);
      send_frame(8'h02, 1'b1, -1, t0);
      idle(20);
      checks++; if (valid !== 1'b1) $display("FAIL b2b_valid: got %b want 1", valid); else passed++;
      checks++; if (data !== 8'h01) $display("FAIL b2b_data_held: got %h want 01", data); else passed++;
      checks++; if (n_over !== 1) $display("FAIL b2b_overrun: got %0d want 1", n_over); else passed++;
      checks++; if (n_frame !== 0) $display("FAIL b2b_frame: got %0d want 0", n_frame); else passed++;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      checks++; if (valid !== 1'b0) $display("FAIL b2b_drain: got %b want 0", valid); else passed++;
      idle(3);
      checks++; if (valid !== 1'b0) $display("FAIL b2b_stays_empty: got %b want 0", valid); else passed++;
   endtask

   task automatic test_reset_midframe();
      int         t0;
      logic [7:0] b;
      ready = 1'b0;
      clear_mon();
      send_frame(8'h5A, 1'b1, -1, t0);
      idle(20);
      checks++; if (valid !== 1'b1 || data !== 8'h5A)
         $display("FAIL rst_pre_hold: got %b/%h want 1/5a", valid, data); else passed++;
      b = 8'h3C;
      send_bit(1'b0);
      for (int i = 0; i < 4; i++) send_bit(b[i]);
      sig_rx = b[4];
      idle(8);
      #2 reset = 1'b1;
      #1;
      checks++; if (valid !== 1'b0) $display("FAIL rst_async_valid: got %b want 0", valid); else passed++;
      checks++; if (data !== 8'h00) $display("FAIL rst_async_data: got %h want 00", data); else passed++;
      checks++; if (dut.state !== IDLE) $display("FAIL rst_async_state: got %0d want IDLE", dut.state); else passed++;
      sig_rx = 1'b1;
      idle(3);
      reset = 1'b0;
      idle(5);
      clear_mon();
      send_frame(8'h3C, 1'b1, -1, t0);
      idle(20);
      checks++; if (valid !== 1'b1 || data !== 8'h3C)
         $display("FAIL rst_after_frame: got %b/%h want 1/3c", valid, data); else passed++;
      ready = 1'b1;
      idle(3);
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int t0;
      ready = 1'b1;
      clear_mon();
      send_frame(8'h07, 1'b1, 0, t0);
      idle(30);
      checks++; if (n_par !== 1) $display("FAIL par_bad_pulse: got %0d want 1", n_par); else passed++;
      checks++; if (n_valid !== 0) $display("FAIL par_bad_valid: got %0d want 0", n_valid); else passed++;
      clear_mon();
      send_frame(8'h07, 1'b1, 1, t0);
      idle(30);
      checks++; if (n_valid !== 1 || last_data !== 8'h07)
         $display("FAIL par_good_data: got %0d/%h want 1/07", n_valid, last_data); else passed++;
      checks++; if (first_valid - t0 < 170 || first_valid - t0 > 172)
         $display("FAIL par_good_latency: got %0d want 171", first_valid - t0); else passed++;
      checks++; if (n_par !== 0) $display("FAIL par_good_pulse: got %0d want 0", n_par); else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_frame_err();
      test_back_to_back();
      test_reset_midframe();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
